// File: rtl/btn_logic_debounced.sv
// Button-to-LED block: synchronise and debounce N_BTN data buttons plus a mode button.
// It then drives four active-low LEDs in one of three views: logic, toggle or count.
// Ports:
//   i_clk, i_rst    : clock, async active-high reset
//   i_btn           : raw data buttons, 1 = pressed
//   i_btn_mode      : raw mode button, 1 = pressed
//   o_led           : LEDs, active-low, registered
//   o_mode          : view, 0 = logic, 1 = toggle, 2 = count
//   o_count         : press counter
module btn_logic_debounced #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic             i_btn_mode,
  output logic [3:0]       o_led,
  output logic [1:0]       o_mode,
  output logic [CNT_W-1:0] o_count
);

  localparam int N_IN = N_BTN + 1;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    M_LOGIC  = 2'd0,
    M_TOGGLE = 2'd1,
    M_COUNT  = 2'd2
  } mode_e;

  logic [N_IN-1:0]  meta_q, sync_q;
  logic [DW-1:0]    dbc_q [N_IN];
  logic [DW-1:0]    dbc_d [N_IN];
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [N_IN-1:0]  stable_dly_q;
  logic [N_IN-1:0]  rise;
  logic [N_BTN-1:0] btn_s;
  mode_e            mode_q, mode_d;
  logic [N_BTN-1:0] tgl_q, tgl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       led_q;
  logic [3:0]       view;

  // Mode button rides along as the top bit of the input vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {i_btn_mode, i_btn};
      sync_q <= meta_q;
    end
  end

  // Count consecutive cycles the synced level differs from the
  // accepted one; any agreeing cycle restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      dbc_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (dbc_q[i] == DB_MAX) begin
          stable_d[i] = sync_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_IN; i++) begin
        dbc_q[i] <= '0;
      end
      stable_q     <= '0;
      stable_dly_q <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  assign rise  = stable_q & ~stable_dly_q;
  assign btn_s = stable_q[N_BTN-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q <= M_LOGIC;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (rise[N_BTN]) begin
      unique case (mode_q)
        M_LOGIC:  mode_d = M_TOGGLE;
        M_TOGGLE: mode_d = M_COUNT;
        default:  mode_d = M_LOGIC;
      endcase
    end
  end

  always_comb begin
    view = '0;
    unique case (mode_q)
      M_LOGIC:  view = {~|btn_s, ^btn_s, |btn_s, &btn_s};
      M_TOGGLE: view[N_BTN-1:0] = tgl_q;
      M_COUNT:  view = cnt_q[3:0];
      default:  view = '0;
    endcase
  end

  // Simultaneous rises bump the counter only once.
  assign tgl_d = tgl_q ^ rise[N_BTN-1:0];
  assign cnt_d = cnt_q + CNT_W'(|rise[N_BTN-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tgl_q <= '0;
      cnt_q <= '0;
      led_q <= 4'b1111;
    end else begin
      tgl_q <= tgl_d;
      cnt_q <= cnt_d;
      led_q <= ~view;
    end
  end

  assign o_led   = led_q;
  assign o_mode  = mode_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_btn_logic_debounced.sv
// Randomised and directed bench for btn_logic_debounced.
// A sample-window reference model predicts LEDs, mode and count.
module tb_btn_logic_debounced;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn = '0;
  logic          bm  = 1'b0;
  logic [3:0]    led;
  logic [1:0]    mode;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_logic_debounced #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn(btn),
    .i_btn_mode(bm),
    .o_led(led),
    .o_mode(mode),
    .o_count(cnt)
  );

  // hist[j] is the raw input vector sampled j edges ago.
  logic [N:0]    hist [D+2];
  logic [N:0]    m_stable;
  logic [N:0]    m_pend;
  logic [N-1:0]  m_tgl;
  logic [CW-1:0] m_cnt;
  logic [1:0]    m_mode;
  logic [3:0]    m_led;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < D + 2; j++) hist[j] = '0;
    m_stable = '0;
    m_pend   = '0;
    m_tgl    = '0;
    m_cnt    = '0;
    m_mode   = 2'd0;
    m_led    = 4'b1111;
  endtask

  // A level is accepted once the last D synchronised samples all
  // agree on it and it differs from the accepted level.
  task automatic model_edge();
    logic [3:0]   v;
    logic [N-1:0] s;
    logic         same;
    if (!rst) begin
      s = m_stable[N-1:0];
      v = '0;
      case (m_mode)
        2'd0: v = {~|s, ^s, |s, &s};
        2'd1: v[N-1:0] = m_tgl;
        2'd2: v = m_cnt[3:0];
        default: v = '0;
      endcase
      if (m_pend[N]) m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
      m_tgl = m_tgl ^ m_pend[N-1:0];
      if (|m_pend[N-1:0]) m_cnt = m_cnt + 1'b1;
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {bm, btn};
      for (int i = 0; i <= N; i++) begin
        same = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (hist[j][i] != hist[2][i]) same = 1'b0;
        m_pend[i] = 1'b0;
        if (same && hist[2][i] != m_stable[i]) begin
          m_stable[i] = hist[2][i];
          m_pend[i]   = hist[2][i];
        end
      end
      m_led = ~v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("led", 32'(led), 32'(m_led));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("count", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_led", 32'(led), 32'hF);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    model_reset();
    @(negedge clk);
    btn = '0;
    bm  = 1'b0;
    rst = 1'b0;
    tick();
    chk("rel_led", 32'(led), 32'b0111);
  endtask

  task automatic press(input logic [N-1:0] b, input logic m);
    btn = b;
    bm  = m;
    repeat (D + 4) tick();
    btn = '0;
    bm  = 1'b0;
    repeat (D + 4) tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("init_led", 32'(led), 32'hF);
    rst = 1'b0;
    tick();

    // reset in the middle of a debounce
    btn = 2'b01;
    repeat (3) tick();
    do_reset();

    // logic view: 01 -> OR and XOR lit; 11 -> AND and OR lit
    btn = 2'b01;
    repeat (6) tick();
    chk("lv_early", 32'(led), 32'b0111);
    tick();
    chk("lv_01", 32'(led), 32'b1001);
    btn = 2'b11;
    repeat (7) tick();
    chk("lv_11", 32'(led), 32'b1100);
    btn = '0;
    repeat (8) tick();
    do_reset();

    // glitch rejection
    btn = 2'b01;
    repeat (3) tick();
    btn = 2'b00;
    tick();
    btn = 2'b01;
    repeat (3) tick();
    btn = 2'b00;
    repeat (10) begin
      tick();
      chk("gl_led", 32'(led), 32'b0111);
      chk("gl_cnt", 32'(cnt), 32'h0);
    end
    do_reset();

    // mode cycling
    press('0, 1'b1);
    chk("mode1", 32'(mode), 32'd1);
    press('0, 1'b1);
    chk("mode2", 32'(mode), 32'd2);
    press('0, 1'b1);
    chk("mode0", 32'(mode), 32'd0);
    do_reset();

    // toggle and count
    press('0, 1'b1);
    press(2'b01, 1'b0);
    press(2'b01, 1'b0);
    press(2'b10, 1'b0);
    chk("tc_led", 32'(led), 32'b1101);
    chk("tc_cnt", 32'(cnt), 32'd3);
    press('0, 1'b1);
    chk("tc_m2", 32'(led), 32'b1100);

    // preload to 255, then a simultaneous press wraps once
    repeat (252) press(2'b01, 1'b0);
    chk("pre_cnt", 32'(cnt), 32'd255);
    press(2'b11, 1'b0);
    chk("wrap_cnt", 32'(cnt), 32'd0);
    press('0, 1'b1);
    press('0, 1'b1);
    chk("wrap_tgl", 32'(led), 32'b1110);

    // random activity on all inputs
    for (int k = 0; k < 400; k++) begin
      btn = N'($urandom_range(0, 3));
      bm  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 7)) tick();
    end
    btn = '0;
    bm  = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
